// File: rtl/systolic_skew_feeder_if.sv
// Valid/ready activation stream from the producer into the skew feeder.
// s_data packs one WIDTH-bit signed element per lane, element i feeding lane i.
interface systolic_skew_feeder_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_last;
  logic [N-1:0][WIDTH-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skews an activation vector stream into a diagonal wavefront for the PE array:
// lane i is delayed 1+i cycles, then zeros are flushed so every lane drains.
module systolic_skew_feeder #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  systolic_skew_feeder_if.slave   s_if,
  output logic [N-1:0][WIDTH-1:0] skew_out_o,
  output logic [N-1:0]            lane_valid_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_W-1:0]        beat_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // The flush counter only has to reach N-2.
  localparam int FCNT_W = (N > 2) ? $clog2(N - 1) : 1;

  state_e             state_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [CNT_W-1:0]   beat_cnt_d;
  logic [FCNT_W-1:0]  flush_cnt_q;
  logic               done_q;
  logic               accept;

  assign s_if.s_ready = (state_q != FLUSH);
  assign accept       = s_if.s_valid & s_if.s_ready;

  // Delay lines free-run: a cycle without an accept injects a zero pad.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [WIDTH-1:0] data_q [gi+1];
      logic [gi:0]      vld_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int s = 0; s <= gi; s++) begin
            data_q[s] <= '0;
          end
          vld_q <= '0;
        end else begin
          data_q[0] <= accept ? s_if.s_data[gi] : '0;
          vld_q[0]  <= accept;
          for (int s = 1; s <= gi; s++) begin
            data_q[s] <= data_q[s-1];
            vld_q[s]  <= vld_q[s-1];
          end
        end
      end

      assign skew_out_o[gi]   = data_q[gi];
      assign lane_valid_o[gi] = vld_q[gi];
    end
  endgenerate

  // First accept of a frame restarts the count; later accepts saturate upward.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      if (state_q == IDLE) begin
        beat_cnt_d = CNT_W'(1);
      end else if (beat_cnt_q != '1) begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      beat_cnt_q <= beat_cnt_d;
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            if (s_if.s_last) begin
              if (N == 1) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else begin
                state_q     <= FLUSH;
                flush_cnt_q <= '0;
              end
            end else begin
              state_q <= STREAM;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_q == FCNT_W'(N - 2)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign beat_cnt_o = beat_cnt_q;

endmodule
